// File: rtl/audio_buffer_writer_pkg.sv
// Shared constants and types for the audio double-buffer path
// (writer, codec interface and RAM wrapper).
package audio_buffer_writer_pkg;

    localparam int BUFFER_ADDR_BITS_DEF = 10;
    localparam int DATA_BITS_DEF        = 8;
    localparam int UNDERRUN_CNT_BITS    = 16;

    typedef enum logic [1:0] {
        FILL,
        FULL,
        ACK,
        SWAP
    } state_t;

endpackage

// File: rtl/audio_buffer_writer_if.sv
// Sample stream handshake into the audio buffer writer.
// The master drives data/valid, the slave returns ready.
interface audio_buffer_writer_if
    import audio_buffer_writer_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic [DATA_BITS-1:0] smp_data_i;
    logic                 smp_valid_i;
    logic                 smp_ready_o;

    modport master (
        output smp_data_i,
        output smp_valid_i,
        input  smp_ready_o
    );

    modport slave (
        input  smp_data_i,
        input  smp_valid_i,
        output smp_ready_o
    );
endinterface

// File: rtl/audio_buffer_writer.sv
// Producer side of the audio double buffer: fills the idle RAM half and
// runs the swap handshake. Optional: AUDIO_BUFFER_UNDERRUN_CNT_EN.
module audio_buffer_writer
    import audio_buffer_writer_pkg::*;
#(
    parameter int BUFFER_ADDR_BITS = BUFFER_ADDR_BITS_DEF,
    parameter int DATA_BITS        = DATA_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    audio_buffer_writer_if.slave      smp,
    output logic [BUFFER_ADDR_BITS:0] ram_wr_addr_o,
    output logic [DATA_BITS-1:0]      ram_wr_data_o,
    output logic                      ram_wren_o,
    input  logic                      buffer_sel_i,
    input  logic                      buffer_empty_i,
    output logic                      buffer_filled_o,
    output logic                      buffer_empty_ack_o,
    output logic                      protocol_err_o
`ifdef AUDIO_BUFFER_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_BITS-1:0] underrun_count_o
`endif
);

    state_t                      state;
    state_t                      state_nxt;
    logic                        target;
    logic [BUFFER_ADDR_BITS-1:0] offset;
    logic                        ready;
    logic                        accept;
    logic                        last;
    logic                        sel_err;
    logic                        swap_done;

    assign accept = smp.smp_valid_i & ready;
    assign last   = accept & (offset == '1);

    // Codec toggling while we own the half we are filling is a protocol error
    assign sel_err   = ((state == FILL) | (state == FULL)) & (buffer_sel_i == target);
    assign swap_done = (state == SWAP) & (buffer_sel_i == target);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (sel_err) begin
                    state_nxt = FILL;
                end else if (last) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (sel_err) begin
                    state_nxt = FILL;
                end else if (buffer_empty_i) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = SWAP;
            end
            SWAP: begin
                if (swap_done) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_comb begin
        ready              = 1'b0;
        buffer_filled_o    = 1'b0;
        buffer_empty_ack_o = 1'b0;
        unique case (state)
            FILL:    ready              = ~rst;
            FULL:    buffer_filled_o    = 1'b1;
            ACK:     buffer_empty_ack_o = 1'b1;
            SWAP:    ready              = 1'b0;
            default: ready              = 1'b0;
        endcase
    end

    assign smp.smp_ready_o = ready;

    // The write taken on an error edge still lands in the old half
    always_ff @(posedge clk) begin
        if (rst) begin
            target         <= ~buffer_sel_i;
            offset         <= '0;
            ram_wren_o     <= 1'b0;
            ram_wr_addr_o  <= '0;
            ram_wr_data_o  <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            ram_wren_o     <= accept;
            protocol_err_o <= sel_err;
            if (accept) begin
                ram_wr_addr_o <= {target, offset};
                ram_wr_data_o <= smp.smp_data_i;
            end
            if (sel_err | swap_done) begin
                target <= ~buffer_sel_i;
                offset <= '0;
            end else if (accept) begin
                offset <= offset + 1'b1;
            end
        end
    end

`ifdef AUDIO_BUFFER_UNDERRUN_CNT_EN
    logic empty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            empty_q          <= 1'b0;
            underrun_count_o <= '0;
        end else begin
            empty_q <= buffer_empty_i;
            if ((state == FILL) & buffer_empty_i & ~empty_q
                & (underrun_count_o != '1)) begin
                underrun_count_o <= underrun_count_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_audio_buffer_writer.sv
// Self-checking bench for audio_buffer_writer: directed scenarios plus
// randomized codec/stream activity against a behavioural model.
module tb_audio_buffer_writer;
    import audio_buffer_writer_pkg::*;

    localparam int AB   = BUFFER_ADDR_BITS_DEF;
    localparam int DB   = DATA_BITS_DEF;
    localparam int HALF = 1 << AB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    logic          empty = 1'b0;
    logic [AB:0]   addr;
    logic [DB-1:0] data;
    logic          wren;
    logic          filled;
    logic          ack;
    logic          err;
`ifdef AUDIO_BUFFER_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_BITS-1:0] urun;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    audio_buffer_writer_if #(.DATA_BITS(DB)) smp ();

    audio_buffer_writer #(
        .BUFFER_ADDR_BITS(AB),
        .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .smp(smp.slave),
        .ram_wr_addr_o(addr),
        .ram_wr_data_o(data),
        .ram_wren_o(wren),
        .buffer_sel_i(sel),
        .buffer_empty_i(empty),
        .buffer_filled_o(filled),
        .buffer_empty_ack_o(ack),
        .protocol_err_o(err)
`ifdef AUDIO_BUFFER_UNDERRUN_CNT_EN
        ,
        .underrun_count_o(urun)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: samples held in the current half, whether the
    // ack is showing, and whether we are waiting for the codec toggle.
    int            m_cnt = 0;
    bit            m_half = 1'b1;
    bit            m_ackout = 1'b0;
    bit            m_acked = 1'b0;
    bit            m_prev_empty = 1'b0;
    int            m_urun = 0;
    bit            e_wren = 1'b0;
    bit            e_err = 1'b0;
    logic [AB:0]   e_addr = '0;
    logic [DB-1:0] e_data = '0;

    always @(posedge clk) begin
        bit in_fill;
        bit in_full;
        bit acc;
        bit perr;
        if (rst) begin
            m_half = !sel;
            m_cnt = 0;
            m_ackout = 0;
            m_acked = 0;
            m_prev_empty = 0;
            m_urun = 0;
            e_wren = 0;
            e_err = 0;
        end else begin
            in_fill = m_cnt < HALF;
            in_full = (m_cnt == HALF) && !m_ackout && !m_acked;
            acc = smp.smp_valid_i && in_fill;
            perr = (in_fill || in_full) && (sel == m_half);
            e_wren = acc;
            e_err = perr;
            if (acc) begin
                e_addr = {m_half, AB'(m_cnt)};
                e_data = smp.smp_data_i;
            end
            if (in_fill && empty && !m_prev_empty && m_urun < 65535) m_urun++;
            m_prev_empty = empty;
            if (perr) begin
                m_half = !sel;
                m_cnt = 0;
                m_acked = 0;
                m_ackout = 0;
            end else if (m_ackout) begin
                m_ackout = 0;
                m_acked = 1;
            end else if (m_acked && sel == m_half) begin
                m_half = !sel;
                m_cnt = 0;
                m_acked = 0;
            end else begin
                if (acc) m_cnt++;
                if (in_full && empty) m_ackout = 1;
            end
        end
        #1;
        check("wren", 32'(wren), 32'(e_wren));
        check("ready", 32'(smp.smp_ready_o), 32'(m_cnt < HALF && !rst));
        check("filled", 32'(filled), 32'(m_cnt == HALF && !m_ackout && !m_acked));
        check("ack", 32'(ack), 32'(m_ackout));
        check("err", 32'(err), 32'(e_err));
        if (e_wren) begin
            check("addr", 32'(addr), 32'(e_addr));
            check("data", 32'(data), 32'(e_data));
        end
`ifdef AUDIO_BUFFER_UNDERRUN_CNT_EN
        check("urun", 32'(urun), 32'(m_urun));
`endif
    end

    initial begin
        int acks;
        bit got;
        int pend;
        smp.smp_valid_i = 1'b0;
        smp.smp_data_i = '0;
        repeat (3) @(negedge clk);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_ready", 32'(smp.smp_ready_o), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_filled", 32'(filled), 32'd0);
        rst = 1'b0;

        // Continuous fill of half 1
        for (int i = 0; i < HALF; i++) begin
            smp.smp_valid_i = 1'b1;
            smp.smp_data_i = DB'(i);
            @(negedge clk);
            if (i == 0) check("first_addr", 32'(addr), 32'h400);
        end
        check("last_wren", 32'(wren), 32'd1);
        check("last_addr", 32'(addr), 32'h7FF);
        check("last_data", 32'(data), 32'hFF);
        check("last_filled", 32'(filled), 32'd1);
        check("last_ready", 32'(smp.smp_ready_o), 32'd0);
        smp.smp_valid_i = 1'b0;
        repeat (3) @(negedge clk);

        // Swap handshake with empty held until the toggle
        empty = 1'b1;
        acks = 0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                got = 1;
                check("ack_latency", 32'(c), 32'd0);
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        repeat (3) begin
            @(negedge clk);
            if (ack) acks++;
            check("swap_ready", 32'(smp.smp_ready_o), 32'd0);
        end
        sel = 1'b1;
        empty = 1'b0;
        @(negedge clk);
        if (ack) acks++;
        check("ack_count", 32'(acks), 32'd1);
        check("resume_ready", 32'(smp.smp_ready_o), 32'd1);

        // Gapped fill of half 0; underrun starts before it completes
        for (int i = 0; i < HALF; i++) begin
            smp.smp_valid_i = 1'b1;
            smp.smp_data_i = DB'($urandom);
            if (i == 900) empty = 1'b1;
            @(negedge clk);
            smp.smp_valid_i = 1'b0;
            if (i == 0) check("gap_first_addr", 32'(addr), 32'h000);
            if (i == HALF - 1) begin
                check("gap_last_addr", 32'(addr), 32'h3FF);
                check("gap_filled", 32'(filled), 32'd1);
                check("gap_no_ack_yet", 32'(ack), 32'd0);
                @(negedge clk);
                check("early_empty_ack", 32'(ack), 32'd1);
                check("ack_filled_low", 32'(filled), 32'd0);
            end else begin
                repeat (2) @(negedge clk);
            end
        end
`ifdef AUDIO_BUFFER_UNDERRUN_CNT_EN
        check("underrun_one", 32'(urun), 32'd1);
`endif
        sel = 1'b0;
        empty = 1'b0;
        repeat (2) @(negedge clk);
        check("swap2_ready", 32'(smp.smp_ready_o), 32'd1);

        // Codec toggles mid-fill at offset 500 of half 1
        for (int i = 0; i < 500; i++) begin
            smp.smp_valid_i = 1'b1;
            smp.smp_data_i = DB'($urandom);
            @(negedge clk);
        end
        sel = 1'b1;
        smp.smp_data_i = 8'hA5;
        @(negedge clk);
        check("perr_pulse", 32'(err), 32'd1);
        check("perr_old_addr", 32'(addr), 32'h5F4);
        check("perr_old_data", 32'(data), 32'hA5);
        smp.smp_data_i = 8'h5A;
        @(negedge clk);
        check("perr_once", 32'(err), 32'd0);
        check("perr_new_addr", 32'(addr), 32'h000);

        // Reset at offset 300 of half 0
        for (int i = 1; i < 300; i++) begin
            smp.smp_data_i = DB'($urandom);
            @(negedge clk);
        end
        check("pre_rst_addr", 32'(addr), 32'd299);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wren", 32'(wren), 32'd0);
        check("mid_rst_ready", 32'(smp.smp_ready_o), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_data", 32'(data), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        smp.smp_data_i = 8'h33;
        @(negedge clk);
        check("post_rst_addr", 32'(addr), 32'h000);
        check("post_rst_data", 32'(data), 32'h33);

        // Randomized stream with a responsive codec and rare faults
        pend = 0;
        for (int c = 0; c < 7000; c++) begin
            smp.smp_valid_i = 1'($urandom_range(0, 1));
            smp.smp_data_i = DB'($urandom);
            rst = ($urandom_range(0, 2999) == 0);
            if (filled && !empty && $urandom_range(0, 3) == 0) empty = 1'b1;
            if (ack) pend = $urandom_range(1, 4);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    sel = !sel;
                    empty = 1'b0;
                end
            end
            if ($urandom_range(0, 999) == 0) sel = !sel;
            if ($urandom_range(0, 1999) == 0) empty = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        smp.smp_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_buffer_writer.md
Name: audio_buffer_writer

Overview:
- Producer side of the audio double buffer. Accepts a sample stream with a valid/ready handshake and writes it into the half of the dual-port RAM the codec interface is not playing.
- Runs the filled / empty / empty_ack swap handshake with the codec interface.
- Drives the RAM write port directly. The RAM clock is the inverted clk, so registered outputs from this block are sampled mid-cycle.

Parameters:
- BUFFER_ADDR_BITS, 10, address bits of one buffer half (half size = 2^BUFFER_ADDR_BITS samples)
- DATA_BITS, 8, sample / RAM word width

Ports:
- clk  in  1  system clock (PLL output)
- rst  in  1  reset; synchronous, active-high
- smp_data_i  in  DATA_BITS  incoming sample
- smp_valid_i  in  1  sample valid
- smp_ready_o  out  1  block can accept a sample this cycle
- ram_wr_addr_o  out  BUFFER_ADDR_BITS+1  RAM write address; MSB = target half, LSBs = offset
- ram_wr_data_o  out  DATA_BITS  RAM write data
- ram_wren_o  out  1  RAM write enable
- buffer_sel_i  in  1  half currently played by the codec (from codec interface)
- buffer_empty_i  in  1  level; codec has finished its half and requests a swap
- buffer_filled_o  out  1  level; the target half is completely written
- buffer_empty_ack_o  out  1  one-cycle pulse acknowledging the swap
- protocol_err_o  out  1  one-cycle pulse on an unexpected buffer_sel_i toggle

Behaviour:
- Reset values: all outputs 0. State = FILL, offset = 0, target half = !buffer_sel_i as sampled during reset.
- States and transitions:
  - FILL: smp_ready_o=1. Each accepted sample (valid & ready at a rising edge) produces ram_wren_o=1 on the next cycle, with ram_wr_data_o = that sample and ram_wr_addr_o = {target, offset}. The offset then increments. Latency is 1 cycle; throughput is 1 sample/cycle.
  - FILL -> FULL: when the sample at offset 2^BUFFER_ADDR_BITS-1 is accepted. smp_ready_o drops on the next cycle. buffer_filled_o rises in the same cycle as that last write's ram_wren_o.
  - FULL: smp_ready_o=0, buffer_filled_o=1. On buffer_empty_i=1 go to ACK.
  - ACK (one cycle): buffer_empty_ack_o=1 and buffer_filled_o=0; then go to SWAP.
  - SWAP: smp_ready_o=0. Wait until buffer_sel_i equals the old target half, i.e. the codec has toggled. Then set target = !buffer_sel_i, offset = 0, and go to FILL.
- buffer_empty_i already high on entry to FULL: ACK follows on the next cycle. No pulse is lost.
- buffer_empty_i high during FILL: ignored (the codec is underrunning). The handshake completes after the fill finishes.
- buffer_sel_i toggles in FILL or FULL: pulse protocol_err_o, retarget to the new !buffer_sel_i, set offset = 0, drop buffer_filled_o, and go to FILL. A write already issued in that cycle completes to the old half.
- Offset wraps only by leaving FILL; it never exceeds 2^BUFFER_ADDR_BITS-1.
- rst mid-operation: an in-flight write is abandoned (ram_wren_o=0 the next cycle) and the block returns to the reset state.

Optional Feature:
- Macro: AUDIO_BUFFER_UNDERRUN_CNT_EN
- With the macro:
  - Adds output underrun_count_o (16 bits, saturating, reset 0).
  - Increments once per rising edge of buffer_empty_i seen while in FILL.
- Without the macro: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - BUFFER_ADDR_BITS and DATA_BITS defaults, also used by the codec interface and the RAM wrapper
  - State encoding enum {FILL, FULL, ACK, SWAP}
  - Underrun counter width
- No sub-module. The write pipeline register and the FSM are small enough to live in one module.

Test Plan:
- Reset with buffer_sel_i=0, then stream 1024 samples 0x00..0xFF repeating with valid always high -> writes to addresses 0x400..0x7FF. ram_wr_data_o matches the sample accepted 1 cycle earlier. buffer_filled_o rises with the write to 0x7FF. smp_ready_o drops the next cycle.
- While FULL, pulse buffer_empty_i high and hold it; toggle buffer_sel_i to 1 three cycles after the ack -> exactly one buffer_empty_ack_o pulse. Writing resumes at 0x000 only after the toggle.
- buffer_empty_i held high before the fill completes -> ack appears 1 cycle after FULL is entered. With AUDIO_BUFFER_UNDERRUN_CNT_EN, underrun_count_o = 1.
- Gapped valid (1 of every 3 cycles) -> no skipped or duplicated addresses. ram_wren_o is high only on cycles following acceptance.
- Toggle buffer_sel_i at offset 500 during FILL -> protocol_err_o pulses for 1 cycle. The next write goes to offset 0 of the new !sel half.
- Assert rst at offset 300 -> all outputs 0 the next cycle. After release, writing restarts at offset 0.
